// File: rtl/asa_riscv_div.sv
// asa_riscv_div: iterative radix-2 RV32M divider (DIV, DIVU, REM, REMU).
// Produces one quotient bit per cycle. It holds ID with div_busy and hands
// one result word to WB, marked by a single-cycle low pulse on div_bubble.
//
// Handshake: an operation is taken only on a rising edge where the FSM is
// idle, Vld=1 and op_instr is a divide/remainder encoding. Vld is ignored at
// all other times. ID must keep the instruction while div_busy=1. The
// result is valid in the one cycle where div_bubble=0.
module asa_riscv_div #(
  parameter int                    XLEN         = 32,
  parameter int                    ALU_OP_WIDTH = 4,
  parameter logic [ALU_OP_WIDTH-1:0] ALU_DIV    = 4'hC,
  parameter logic [ALU_OP_WIDTH-1:0] ALU_DIVU   = 4'hD,
  parameter logic [ALU_OP_WIDTH-1:0] ALU_REM    = 4'hE,
  parameter logic [ALU_OP_WIDTH-1:0] ALU_REMU   = 4'hF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    Vld,
  input  logic [ALU_OP_WIDTH-1:0] op_instr,
  input  logic [XLEN-1:0]         opA,
  input  logic [XLEN-1:0]         opB,
  output logic                    div_busy,
  output logic                    div_bubble,
  output logic [XLEN-1:0]         div_r,
  output logic [1:0]              o_dbg_state
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_div_r;
  logic              r_bubble;
  logic              r_busy;
  // r_quot starts out holding the dividend magnitude. Dividend bits leave at
  // the top while quotient bits enter at the bottom.
  logic [XLEN-1:0]   r_quot;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_dvsr;
  logic              r_is_rem;
  logic              r_neg_q;
  logic              r_neg_r;

  logic              w_op_ok;
  logic              w_signed;
  logic              w_is_rem;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic [XLEN:0]     w_shift_rem;
  logic [XLEN:0]     w_trial;
  logic [XLEN-1:0]   w_q_fixed;
  logic [XLEN-1:0]   w_r_fixed;
  logic [XLEN-1:0]   w_result;

  assign w_op_ok  = (op_instr == ALU_DIV) || (op_instr == ALU_DIVU) ||
                    (op_instr == ALU_REM) || (op_instr == ALU_REMU);
  assign w_signed = (op_instr == ALU_DIV) || (op_instr == ALU_REM);
  assign w_is_rem = (op_instr == ALU_REM) || (op_instr == ALU_REMU);

  // Magnitudes: signed ops use the two's-complement absolute value.
  assign w_abs_a = (w_signed && opA[XLEN-1]) ? -opA : opA;
  assign w_abs_b = (w_signed && opB[XLEN-1]) ? -opB : opB;

  // Restoring step. The remainder is always below the divisor, so the
  // XLEN+1-bit trial difference is non-negative exactly when its MSB is 0.
  assign w_shift_rem = {r_rem, r_quot[XLEN-1]};
  assign w_trial     = w_shift_rem - {1'b0, r_dvsr};

  assign w_q_fixed = r_neg_q ? -r_quot : r_quot;
  assign w_r_fixed = r_neg_r ? -r_rem  : r_rem;
  assign w_result  = r_is_rem ? w_r_fixed : w_q_fixed;

  assign div_busy    = r_busy;
  assign div_bubble  = r_bubble;
  assign div_r       = r_div_r;
  assign o_dbg_state = r_state;

  // Divider FSM: accept, iterate, sign-fix, and register the outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_div_r  <= '0;
      r_bubble <= 1'b1;
      r_busy   <= 1'b0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_dvsr   <= '0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      r_bubble <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (Vld && w_op_ok) begin
            r_busy   <= 1'b1;
            r_is_rem <= w_is_rem;
            if (opB == '0) begin
              // Divide by zero: no iteration and no sign correction.
              r_quot  <= '1;
              r_rem   <= opA;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_state <= ST_FIX;
            end else if (w_signed && (opA == MIN_NEG) && (opB == '1)) begin
              // Signed overflow: the result is fixed by the ISA.
              r_quot  <= MIN_NEG;
              r_rem   <= '0;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_state <= ST_FIX;
            end else begin
              r_quot  <= w_abs_a;
              r_rem   <= '0;
              r_dvsr  <= w_abs_b;
              r_neg_q <= w_signed && (opA[XLEN-1] ^ opB[XLEN-1]);
              r_neg_r <= w_signed && opA[XLEN-1];
              r_cnt   <= CNT_W'(XLEN - 1);
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (!w_trial[XLEN]) begin
            r_rem  <= w_trial[XLEN-1:0];
            r_quot <= {r_quot[XLEN-2:0], 1'b1};
          end else begin
            r_rem  <= w_shift_rem[XLEN-1:0];
            r_quot <= {r_quot[XLEN-2:0], 1'b0};
          end
          if (r_cnt == '0) begin
            r_state <= ST_FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_FIX: begin
          r_div_r  <= w_result;
          r_bubble <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_asa_riscv_div.sv
// tb_asa_riscv_div: self-checking bench for the iterative RV32M divider.
module tb_asa_riscv_div;

  localparam logic [3:0] OP_DIV  = 4'hC;
  localparam logic [3:0] OP_DIVU = 4'hD;
  localparam logic [3:0] OP_REM  = 4'hE;
  localparam logic [3:0] OP_REMU = 4'hF;
  localparam logic [3:0] OP_ADD  = 4'h0;

  logic        clk;
  logic        rstn;
  logic        Vld;
  logic [3:0]  op_instr;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        div_busy;
  logic        div_bubble;
  logic [31:0] div_r;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  asa_riscv_div dut (
    .clk         (clk),
    .rstn        (rstn),
    .Vld         (Vld),
    .op_instr    (op_instr),
    .opA         (opA),
    .opB         (opB),
    .div_busy    (div_busy),
    .div_bubble  (div_bubble),
    .div_r       (div_r),
    .o_dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model: RV32M divide semantics from plain arithmetic.
  function automatic logic [31:0] ref_result(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU: return (b == 0) ? a : a % b;
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      default: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (b == 0) return 1;
    if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1;
    return 33;
  endfunction

  // Scoreboard compare
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver: issue one op, wait for the bubble, check result and timing.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input string name);
    int low_c;
    int busy_c;
    logic [31:0] exp;
    exp_q.push_back(ref_result(op, a, b));
    @(negedge clk);
    Vld = 1'b1; op_instr = op; opA = a; opB = b;
    @(posedge clk);
    #1 Vld = 1'b0;
    low_c = 0;
    busy_c = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (div_busy) busy_c++;
      if (!div_bubble) begin
        low_c = c;
        break;
      end
    end
    exp = exp_q.pop_front();
    check({name, "_bubble_cycle"}, 32'(low_c), 32'(lat + 1));
    check({name, "_result"}, div_r, exp);
    check({name, "_busy_cycles"}, 32'(busy_c), 32'(lat));
    check({name, "_busy_at_bubble"}, {31'b0, div_busy}, 32'h0);
    @(negedge clk);
    check({name, "_bubble_single"}, {31'b0, div_bubble}, 32'h1);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] held;
    int          lows;
    logic [3:0]  ops[4];

    ops[0] = OP_DIV; ops[1] = OP_DIVU; ops[2] = OP_REM; ops[3] = OP_REMU;

    vecs[0]  = '{OP_DIV,  32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 33};
    vecs[1]  = '{OP_REM,  32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, 33};
    vecs[2]  = '{OP_REM,  32'd20,        32'hFFFF_FFFD, 32'd2,         33};
    vecs[3]  = '{OP_DIVU, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 33};
    vecs[4]  = '{OP_REMU, 32'hFFFF_FFFF, 32'h10,        32'hF,         33};
    vecs[5]  = '{OP_DIV,  32'd7,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[6]  = '{OP_REM,  32'd7,         32'd0,         32'd7,         1};
    vecs[7]  = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[8]  = '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
    vecs[9]  = '{OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33};
    vecs[10] = '{OP_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         33};
    vecs[11] = '{OP_REMU, 32'd5,         32'd0,         32'd5,         1};

    rstn = 1'b0; Vld = 1'b0; op_instr = OP_ADD; opA = '0; opB = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'b0, div_busy}, 32'h0);
    check("reset_bubble", {31'b0, div_bubble}, 32'h1);
    check("reset_div_r", div_r, 32'h0);
    rstn = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      check($sformatf("vec%0d_model", i),
            ref_result(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Vld while busy: offers at E0+5 and E0+33 must be ignored.
    @(negedge clk);
    Vld = 1'b1; op_instr = OP_DIV; opA = 32'd100; opB = 32'hFFFF_FFF9;
    @(posedge clk);
    #1 Vld = 1'b0;
    lows = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!div_bubble) lows++;
      if (k == 34) begin
        check("busyvld_result", div_r, ref_result(OP_DIV, 32'd100, 32'hFFFF_FFF9));
        check("busyvld_busy_after", {31'b0, div_busy}, 32'h0);
      end
      Vld = (k == 5 || k == 33);
      op_instr = OP_DIVU; opA = 32'd9; opB = 32'd3;
    end
    Vld = 1'b0;
    check("busyvld_one_result", 32'(lows), 32'd1);
    check("busyvld_idle", {31'b0, div_busy}, 32'h0);
    run_op(OP_DIVU, 32'd9, 32'd3, 33, "reissue");

    // Reset mid-operation at E0+10
    @(negedge clk);
    Vld = 1'b1; op_instr = OP_DIVU; opA = 32'd1000; opB = 32'd7;
    @(posedge clk);
    #1 Vld = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'b0, div_busy}, 32'h0);
    check("midrst_bubble", {31'b0, div_bubble}, 32'h1);
    check("midrst_div_r", div_r, 32'h0);
    rstn = 1'b1;
    lows = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!div_bubble) lows++;
    end
    check("midrst_no_bubble", 32'(lows), 32'd0);

    // Unrecognised op in idle
    run_op(OP_REMU, 32'd123, 32'd10, 33, "pre_unrec");
    held = div_r;
    @(negedge clk);
    Vld = 1'b1; op_instr = OP_ADD; opA = 32'd50; opB = 32'd5;
    @(negedge clk);
    Vld = 1'b0;
    lows = 0;
    for (int k = 0; k < 40; k++) begin
      if (!div_bubble || div_busy) lows++;
      @(negedge clk);
    end
    check("unrec_no_activity", 32'(lows), 32'd0);
    check("unrec_div_r_held", div_r, held);

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 3)];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = $urandom_range(1, 15);
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = -($urandom_range(1, 15));
        default: ;
      endcase
      run_op(op, a, b, ref_lat(op, a, b), $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
